// File: rtl/issue_scheduler.sv
// Dual-issue scheduler between the issue buffer head pair and EX.
// Decides the pop count and lane fire mask each cycle. It owns the load-use
// scoreboard, the divider occupancy counter and the CSR/exception drain FSM.
// Optional feature macro: DUAL_ISSUE_EN (defined = slot b may issue with slot a).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal issue
// ST_DRAIN | serializing op in flight, nothing issues until drn_cnt hits 0
module issue_scheduler #(
   parameter int DIV_LAT   = 18,
   parameter int DRAIN_LAT = 3
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       flush_BR,
   input  logic       stall_DCache,
   input  logic       stall_div,
   input  logic [1:0] is_valid,
   input  logic [2:0] a_class,
   input  logic [2:0] b_class,
   input  logic       a_rf_we,
   input  logic       b_rf_we,
   input  logic [4:0] a_rf_rd,
   input  logic [4:0] b_rf_rd,
   input  logic [4:0] a_rf_raddr1,
   input  logic [4:0] a_rf_raddr2,
   input  logic [4:0] b_rf_raddr1,
   input  logic [4:0] b_rf_raddr2,
   output logic [1:0] using_num,
   output logic [1:0] issue_valid,
   output logic       div_busy
);

   localparam logic [2:0] C_LD  = 3'd1;
   localparam logic [2:0] C_ST  = 3'd2;
   localparam logic [2:0] C_BR  = 3'd3;
   localparam logic [2:0] C_DIV = 3'd4;
   localparam logic [2:0] C_CSR = 3'd5;
   localparam logic [2:0] C_EXC = 3'd6;

   localparam int DIV_W = $clog2(DIV_LAT);
   localparam int DRN_W = $clog2(DRAIN_LAT) + 1;

`ifdef DUAL_ISSUE_EN
   localparam bit DUAL_EN = 1'b1;
`else
   localparam bit DUAL_EN = 1'b0;
`endif

   typedef enum logic {ST_RUN, ST_DRAIN} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
   logic               ld_pend_q, ld_pend_d;
   logic [4:0]         ld_rd_q, ld_rd_d;

   logic stall, kill, lu_a, lu_b, a_mem, b_mem, a_ok, b_ok, a_iss, b_iss;

   assign div_busy = (div_cnt_q != '0);

   // Issue decision for the head pair: purely combinational from inputs and state.
   always_comb begin
      stall = stall_DCache | stall_div;
      kill  = flush_BR | stall | ~is_valid[1];
      lu_a  = ld_pend_q && (ld_rd_q != 5'd0) &&
              ((ld_rd_q == a_rf_raddr1) || (ld_rd_q == a_rf_raddr2));
      lu_b  = ld_pend_q && (ld_rd_q != 5'd0) &&
              ((ld_rd_q == b_rf_raddr1) || (ld_rd_q == b_rf_raddr2));
      a_mem = (a_class == C_LD) || (a_class == C_ST);
      b_mem = (b_class == C_LD) || (b_class == C_ST);
      a_ok  = (state_q == ST_RUN) && !lu_a && !((a_class == C_DIV) && div_busy);
      b_ok  = is_valid[0] &&
              !((a_class == C_BR) || (a_class == C_CSR) || (a_class == C_EXC)) &&
              !((b_class == C_CSR) || (b_class == C_EXC) || (b_class == C_DIV)) &&
              !(a_mem && b_mem) &&
              !(a_rf_we && (a_rf_rd != 5'd0) &&
                ((a_rf_rd == b_rf_raddr1) || (a_rf_rd == b_rf_raddr2))) &&
              !(a_rf_we && b_rf_we && (a_rf_rd != 5'd0) && (a_rf_rd == b_rf_rd)) &&
              !lu_b;
      a_iss = !kill && a_ok;
      b_iss = DUAL_EN && a_iss && b_ok;
      issue_valid = {a_iss, b_iss};
      using_num   = {1'b0, a_iss} + {1'b0, b_iss};
   end

   // Next-state: divider always counts; flush beats stall; stall freezes the rest.
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      drn_cnt_d = drn_cnt_q;
      ld_pend_d = ld_pend_q;
      ld_rd_d   = ld_rd_q;

      if (a_iss && (a_class == C_DIV))
         div_cnt_d = DIV_W'(DIV_LAT - 1);
      else if (div_cnt_q != '0)
         div_cnt_d = div_cnt_q - 1'b1;

      if (flush_BR) begin
         state_d   = ST_RUN;
         drn_cnt_d = '0;
         ld_pend_d = 1'b0;
         ld_rd_d   = 5'd0;
      end else if (!stall) begin
         // Younger slot wins; a and b can never both be loads.
         ld_pend_d = 1'b0;
         if (a_iss && (a_class == C_LD) && a_rf_we) begin
            ld_pend_d = 1'b1;
            ld_rd_d   = a_rf_rd;
         end
         if (b_iss && (b_class == C_LD) && b_rf_we) begin
            ld_pend_d = 1'b1;
            ld_rd_d   = b_rf_rd;
         end
         case (state_q)
            ST_RUN: begin
               if (a_iss && ((a_class == C_CSR) || (a_class == C_EXC))) begin
                  state_d   = ST_DRAIN;
                  drn_cnt_d = DRN_W'(DRAIN_LAT - 1);
               end
            end
            ST_DRAIN: begin
               if (drn_cnt_q == '0)
                  state_d = ST_RUN;
               else
                  drn_cnt_d = drn_cnt_q - 1'b1;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_RUN;
         div_cnt_q <= '0;
         drn_cnt_q <= '0;
         ld_pend_q <= 1'b0;
         ld_rd_q   <= 5'd0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         drn_cnt_q <= drn_cnt_d;
         ld_pend_q <= ld_pend_d;
         ld_rd_q   <= ld_rd_d;
      end
   end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random pairs, checked by
// a queue-based scoreboard against a cycle-index reference model.
module tb_issue_scheduler;

   localparam int DIV_LAT   = 18;
   localparam int DRAIN_LAT = 3;
`ifdef DUAL_ISSUE_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   localparam logic [2:0] ALU = 3'd0, LD = 3'd1, ST = 3'd2, BR = 3'd3,
                          DIV = 3'd4, CSR = 3'd5, EXC = 3'd6;

   typedef struct {
      logic       fl, sd, sv;
      logic [1:0] v;
      logic [2:0] ac, bc;
      logic       awe, bwe;
      logic [4:0] ard, brd, a1, a2, b1, b2;
   } stim_t;

   typedef struct packed {
      logic [1:0] un;
      logic [1:0] iv;
      logic       db;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] using_num, issue_valid;
   logic       div_busy;
   stim_t      cur;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // reference model state
   int   cyc;
   int   div_t;
   int   drain_left;
   bit   ld_valid;
   logic [4:0] ld_rd;
   bit   last_ai, last_bi;

   issue_scheduler #(.DIV_LAT(DIV_LAT), .DRAIN_LAT(DRAIN_LAT)) dut (
      .clk(clk), .rstn(rstn),
      .flush_BR(cur.fl), .stall_DCache(cur.sd), .stall_div(cur.sv),
      .is_valid(cur.v), .a_class(cur.ac), .b_class(cur.bc),
      .a_rf_we(cur.awe), .b_rf_we(cur.bwe),
      .a_rf_rd(cur.ard), .b_rf_rd(cur.brd),
      .a_rf_raddr1(cur.a1), .a_rf_raddr2(cur.a2),
      .b_rf_raddr1(cur.b1), .b_rf_raddr2(cur.b2),
      .using_num(using_num), .issue_valid(issue_valid), .div_busy(div_busy)
   );

   always #5 clk = ~clk;

   function automatic bit reads(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
      return (rd != 5'd0) && ((rd == s1) || (rd == s2));
   endfunction

   function automatic bit is_mem(input logic [2:0] c);
      return (c == LD) || (c == ST);
   endfunction

   // divider busy during the DIV_LAT-1 cycles that follow the issuing cycle
   function automatic bit model_busy();
      return (div_t >= 0) && (cyc - div_t >= 1) && (cyc - div_t <= DIV_LAT - 1);
   endfunction

   function automatic stim_t pair(input logic [1:0] v,
                                  input logic [2:0] ac, input logic awe, input logic [4:0] ard,
                                  input logic [4:0] a1, input logic [4:0] a2,
                                  input logic [2:0] bc, input logic bwe, input logic [4:0] brd,
                                  input logic [4:0] b1, input logic [4:0] b2);
      stim_t s;
      s.fl = 1'b0; s.sd = 1'b0; s.sv = 1'b0; s.v = v;
      s.ac = ac; s.awe = awe; s.ard = ard; s.a1 = a1; s.a2 = a2;
      s.bc = bc; s.bwe = bwe; s.brd = brd; s.b1 = b1; s.b2 = b2;
      return s;
   endfunction

   function automatic stim_t idle();
      return pair(2'b00, ALU, 1'b0, 5'd0, 5'd0, 5'd0, ALU, 1'b0, 5'd0, 5'd0, 5'd0);
   endfunction

   task automatic model_reset();
      div_t = -1; drain_left = 0; ld_valid = 0; ld_rd = 5'd0;
      last_ai = 0; last_bi = 0;
   endtask

   task automatic model_decide();
      bit kill;
      kill    = cur.fl || cur.sd || cur.sv || !cur.v[1];
      last_ai = !kill && (drain_left == 0) && !(ld_valid && reads(ld_rd, cur.a1, cur.a2)) &&
                !((cur.ac == DIV) && model_busy());
      last_bi = DUAL && last_ai && cur.v[0] &&
                !(cur.ac inside {BR, CSR, EXC}) && !(cur.bc inside {CSR, EXC, DIV}) &&
                !(is_mem(cur.ac) && is_mem(cur.bc)) &&
                !(cur.awe && reads(cur.ard, cur.b1, cur.b2)) &&
                !(cur.awe && cur.bwe && (cur.ard != 5'd0) && (cur.ard == cur.brd)) &&
                !(ld_valid && reads(ld_rd, cur.b1, cur.b2));
   endtask

   // Applies the consequences of the cycle that just ended at a posedge.
   task automatic model_edge();
      if (cur.fl) begin
         drain_left = 0;
         ld_valid   = 0;
      end else if (!(cur.sd || cur.sv)) begin
         if (drain_left > 0)
            drain_left--;
         else if (last_ai && (cur.ac inside {CSR, EXC}))
            drain_left = DRAIN_LAT;
         if (last_ai && (cur.ac == DIV))
            div_t = cyc;
         ld_valid = 0;
         if (last_ai && (cur.ac == LD) && cur.awe) begin ld_valid = 1; ld_rd = cur.ard; end
         if (last_bi && (cur.bc == LD) && cur.bwe) begin ld_valid = 1; ld_rd = cur.brd; end
      end
      cyc++;
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      @(posedge clk);
      model_edge();
      #1;
      cur = s;
      model_decide();
      e.un = 2'(int'(last_ai) + int'(last_bi));
      e.iv = {last_ai, last_bi};
      e.db = model_busy();
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: compares one expected entry per cycle, mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         automatic exp_t e = exp_q.pop_front();
         checks++;
         if ({using_num, issue_valid, div_busy} !== e) begin
            errors++;
            $display("FAIL sched t=%0t using_num/issue_valid/div_busy got %b/%b/%b want %b/%b/%b",
                     $time, using_num, issue_valid, div_busy, e.un, e.iv, e.db);
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      stim_t s;
      int blocked;
      cur  = idle();
      rstn = 1'b0;
      cyc  = 0;
      model_reset();
      #12;
      check("reset_using_num", int'(using_num), 0);
      check("reset_issue_valid", int'(issue_valid), 0);
      check("reset_div_busy", int'(div_busy), 0);
      @(negedge clk);
      rstn = 1'b1;

      // independent ALU pairs
      repeat (4) step(pair(2'b11, ALU, 1, 5'd1, 5'd2, 5'd3, ALU, 1, 5'd4, 5'd5, 5'd6));

      // load-use bubble
      step(pair(2'b11, LD, 1, 5'd4, 5'd1, 5'd2, ALU, 1, 5'd7, 5'd1, 5'd2));
      step(pair(2'b11, ALU, 1, 5'd5, 5'd4, 5'd0, ALU, 1, 5'd8, 5'd1, 5'd0));
      step(pair(2'b11, ALU, 1, 5'd5, 5'd4, 5'd0, ALU, 1, 5'd8, 5'd1, 5'd0));

      // intra-pair RAW, then the dependent op moves to slot a
      step(pair(2'b11, ALU, 1, 5'd3, 5'd1, 5'd2, ALU, 1, 5'd9, 5'd3, 5'd1));
      step(pair(2'b10, ALU, 1, 5'd9, 5'd3, 5'd1, ALU, 0, 5'd0, 5'd0, 5'd0));

      // divider occupancy: second DIV blocked DIV_LAT-1 cycles
      step(pair(2'b10, DIV, 1, 5'd6, 5'd1, 5'd2, ALU, 0, 5'd0, 5'd0, 5'd0));
      blocked = 0;
      repeat (DIV_LAT - 1) begin
         step(pair(2'b10, DIV, 1, 5'd7, 5'd1, 5'd2, ALU, 0, 5'd0, 5'd0, 5'd0));
         #2;
         if (using_num == 2'b00 && div_busy) blocked++;
      end
      check("div_blocked_cycles", blocked, DIV_LAT - 1);
      step(pair(2'b10, DIV, 1, 5'd7, 5'd1, 5'd2, ALU, 0, 5'd0, 5'd0, 5'd0));
      #2;
      check("div_second_issue", int'(using_num), 1);

      // CSR drain then resume (wait out the divider first)
      repeat (DIV_LAT) step(idle());
      step(pair(2'b11, CSR, 1, 5'd1, 5'd0, 5'd0, ALU, 1, 5'd2, 5'd3, 5'd0));
      blocked = 0;
      repeat (DRAIN_LAT) begin
         step(pair(2'b11, ALU, 1, 5'd2, 5'd3, 5'd0, ALU, 1, 5'd4, 5'd5, 5'd0));
         #2;
         if (using_num == 2'b00) blocked++;
      end
      check("drain_cycles", blocked, DRAIN_LAT);
      step(pair(2'b11, ALU, 1, 5'd2, 5'd3, 5'd0, ALU, 1, 5'd4, 5'd5, 5'd0));

      // flush during DRAIN
      step(pair(2'b10, EXC, 0, 5'd0, 5'd0, 5'd0, ALU, 0, 5'd0, 5'd0, 5'd0));
      s = pair(2'b11, ALU, 1, 5'd2, 5'd3, 5'd0, ALU, 1, 5'd4, 5'd5, 5'd0);
      s.fl = 1'b1;
      step(s);
      s.fl = 1'b0;
      step(s);

      // flush clears a pending load-use hazard; stall+flush together
      step(pair(2'b10, LD, 1, 5'd4, 5'd1, 5'd0, ALU, 0, 5'd0, 5'd0, 5'd0));
      s = pair(2'b10, ALU, 1, 5'd5, 5'd4, 5'd0, ALU, 0, 5'd0, 5'd0, 5'd0);
      s.fl = 1'b1; s.sd = 1'b1;
      step(s);
      s.fl = 1'b0; s.sd = 1'b0;
      step(s);

      // async reset mid-DIV
      step(pair(2'b10, DIV, 1, 5'd6, 5'd1, 5'd2, ALU, 0, 5'd0, 5'd0, 5'd0));
      step(idle());
      step(idle());
      @(negedge clk);
      #1;
      check("pre_reset_div_busy", int'(div_busy), 1);
      rstn = 1'b0;
      #1;
      check("async_reset_div_busy", int'(div_busy), 0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;

      // random traffic
      repeat (3000) begin
         int r;
         s.v   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
         r = $urandom_range(0, 15);
         s.ac  = (r < 6 || r == 15) ? ALU : (r < 8) ? LD : (r < 10) ? ST : (r < 12) ? BR :
                 (r == 12) ? DIV : (r == 13) ? CSR : EXC;
         r = $urandom_range(0, 15);
         s.bc  = (r < 6 || r == 15) ? ALU : (r < 8) ? LD : (r < 10) ? ST : (r < 12) ? BR :
                 (r == 12) ? DIV : (r == 13) ? CSR : EXC;
         s.awe = 1'($urandom_range(0, 3) != 0);
         s.bwe = 1'($urandom_range(0, 3) != 0);
         s.ard = 5'($urandom_range(0, 5));
         s.brd = 5'($urandom_range(0, 5));
         s.a1  = 5'($urandom_range(0, 5));
         s.a2  = 5'($urandom_range(0, 5));
         s.b1  = 5'($urandom_range(0, 5));
         s.b2  = 5'($urandom_range(0, 5));
         s.fl  = 1'($urandom_range(0, 19) == 0);
         s.sd  = 1'($urandom_range(0, 9) == 0);
         s.sv  = 1'($urandom_range(0, 9) == 0);
         step(s);
      end

      step(idle());
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
